// File: rtl/ew_gate_join.sv
// Element-wise gated join: buffers s beats, pairs each with a g beat and emits
// (s*g)>>>G_FRAC_BITS per lane. Define EW_GATE_SAT_EN to clamp results and enable sat_flag.
module ew_gate_join #(
    parameter int LANES       = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int G_FRAC_BITS = 8,
    parameter int S_DEPTH     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [LANES*DATA_WIDTH-1:0]        s_data,
    input  logic                               g_valid,
    output logic                               g_ready,
    input  logic [LANES*DATA_WIDTH-1:0]        g_data,
    input  logic                               g_bypass,
    output logic                               y_valid,
    input  logic                               y_ready,
    output logic [LANES*DATA_WIDTH-1:0]        y_data,
    output logic [$clog2(S_DEPTH+1)-1:0]       s_count,
    output logic                               sat_flag
);

    localparam int W     = LANES * DATA_WIDTH;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int PTR_W = $clog2(S_DEPTH);
    localparam int CNT_W = $clog2(S_DEPTH + 1);

`ifdef EW_GATE_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic lane_clamps(input logic signed [PW-1:0] prod);
        logic signed [PW-1:0] shifted;
        shifted = prod >>> G_FRAC_BITS;
        return (shifted > SAT_MAX) || (shifted < SAT_MIN);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_result(input logic signed [PW-1:0] prod);
        logic signed [PW-1:0] shifted;
        shifted = prod >>> G_FRAC_BITS;
        if (shifted > SAT_MAX)
            return SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            return SAT_MIN[DATA_WIDTH-1:0];
        else
            return shifted[DATA_WIDTH-1:0];
    endfunction
`else
    function automatic logic [DATA_WIDTH-1:0] lane_result(input logic signed [PW-1:0] prod);
        return prod[G_FRAC_BITS +: DATA_WIDTH];
    endfunction
`endif

    logic [W-1:0]         s_mem [S_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 s_push, join_fire, adv1, adv2;
    logic [W-1:0]         s_head;
    logic signed [PW-1:0] prod_c [LANES];

    logic [W-1:0]         s_p1;
    logic signed [PW-1:0] prod_p1 [LANES];
    logic                 byp_p1, vld_p1;
    logic [W-1:0]         y_c;

    // Readiness depends only on registered occupancy and downstream state, never on this cycle's pop.
    assign adv2      = !y_valid || y_ready;
    assign adv1      = !vld_p1 || adv2;
    assign s_ready   = !rst && (s_count != CNT_W'(S_DEPTH));
    assign g_ready   = !rst && (s_count != '0) && adv1;
    assign s_push    = s_valid && s_ready;
    assign join_fire = g_valid && g_ready;
    assign s_head    = s_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (s_push)
            s_mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            s_count <= '0;
        end else begin
            if (s_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (join_fire)
                rd_ptr <= rd_ptr + 1'b1;
            if (s_push && !join_fire)
                s_count <= s_count + 1'b1;
            else if (!s_push && join_fire)
                s_count <= s_count - 1'b1;
        end
    end

    always_comb begin
        logic signed [PW-1:0] s_ext, g_ext;
        s_ext = '0;
        g_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            s_ext = {{DATA_WIDTH{s_head[i*DATA_WIDTH+DATA_WIDTH-1]}}, s_head[i*DATA_WIDTH +: DATA_WIDTH]};
            g_ext = {{DATA_WIDTH{g_data[i*DATA_WIDTH+DATA_WIDTH-1]}}, g_data[i*DATA_WIDTH +: DATA_WIDTH]};
            prod_c[i] = s_ext * g_ext;
        end
    end

    // ---- stage 1: products, bypass flag and raw s ----
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (adv1)
            vld_p1 <= join_fire;
    end

    always_ff @(posedge clk) begin
        if (adv1 && join_fire) begin
            s_p1    <= s_head;
            prod_p1 <= prod_c;
            byp_p1  <= g_bypass;
        end
    end

`ifdef EW_GATE_SAT_EN
    logic sat_c, sat_p2;
`endif

    always_comb begin
        y_c = '0;
`ifdef EW_GATE_SAT_EN
        sat_c = 1'b0;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (byp_p1) begin
                y_c[i*DATA_WIDTH +: DATA_WIDTH] = s_p1[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                y_c[i*DATA_WIDTH +: DATA_WIDTH] = lane_result(prod_p1[i]);
`ifdef EW_GATE_SAT_EN
                sat_c = sat_c | lane_clamps(prod_p1[i]);
`endif
            end
        end
    end

    // ---- stage 2: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
`ifdef EW_GATE_SAT_EN
            sat_p2  <= 1'b0;
`endif
        end else if (adv2) begin
            y_valid <= vld_p1;
            if (vld_p1) begin
                y_data <= y_c;
`ifdef EW_GATE_SAT_EN
                sat_p2 <= sat_c;
`endif
            end
        end
    end

`ifdef EW_GATE_SAT_EN
    // Sticky: only clamps on beats the consumer actually took count.
    always_ff @(posedge clk) begin
        if (rst)
            sat_flag <= 1'b0;
        else if (y_valid && y_ready && sat_p2)
            sat_flag <= 1'b1;
    end
`else
    assign sat_flag = 1'b0;
`endif

endmodule
